mips_avalon_bus_master: RTL and testbench

- Bus interface unit between the MIPS core and the single Avalon memory-mapped master port driving mips_avalon_slave.
- Arbitrates two core requesters onto that one port:
  - instruction fetch, read-only;
  - data load/store, with byteenable.
- Sequences each transaction with full waitrequest compliance and returns read data with a one-cycle acknowledge pulse.

---
 rtl/mips_bus_pkg.sv | 31 +++
 rtl/mips_bus_rr_arbiter.sv | 51 +++++
 rtl/mips_avalon_bus_master.sv | 143 ++++++++++++++
 tb/tb_mips_avalon_bus_master.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS Avalon bus interface unit.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_e;

  typedef enum logic {
    GNT_INSTR,
    GNT_DATA
  } grant_e;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  localparam logic [BE_W-1:0] WORD_BE_ALL = 4'b1111;

  // Registered Avalon command payload (address is held separately, its width is a parameter)
  typedef struct packed {
    logic              read;
    logic              write;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } avm_cmd_t;

endpackage

// File: rtl/mips_bus_rr_arbiter.sv
// Two-requester arbiter: fixed data priority or round-robin, with a registered last grant.
module mips_bus_rr_arbiter
  import mips_bus_pkg::*;
#(
  parameter int unsigned ARB_MODE = ARB_RR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_req,
  input  logic       d_req,
  input  logic       done,
  input  grant_e     done_gnt,
  output logic [1:0] gnt_c
);

  grant_e last_gnt;

  // Reset to instr so data wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= GNT_INSTR;
    end else if (done) begin
      last_gnt <= done_gnt;
    end
  end

  // gnt_c[0] = instr, gnt_c[1] = data
  always_comb begin
    gnt_c = 2'b00;
    if (ARB_MODE == ARB_FIXED) begin
      if (d_req) begin
        gnt_c[1] = 1'b1;
      end else if (i_req) begin
        gnt_c[0] = 1'b1;
      end
    end else begin
      if (i_req && d_req) begin
        if (last_gnt == GNT_DATA) begin
          gnt_c[0] = 1'b1;
        end else begin
          gnt_c[1] = 1'b1;
        end
      end else if (d_req) begin
        gnt_c[1] = 1'b1;
      end else if (i_req) begin
        gnt_c[0] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mips_avalon_bus_master.sv
// Bus interface unit: arbitrates instruction fetch and data access onto one Avalon master port.
module mips_avalon_bus_master
  import mips_bus_pkg::*;
#(
  parameter int unsigned ARB_MODE = ARB_RR,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [BE_W-1:0]   d_be,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  output logic [DATA_W-1:0] writedata,
  output logic [BE_W-1:0]   byteenable,
  input  logic              waitrequest,
  input  logic [DATA_W-1:0] readdata,
  output logic              busy
);

  state_e            state_q, state_d;
  grant_e            gnt_q, gnt_d;
  avm_cmd_t          cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              i_ack_d, d_ack_d, busy_d;
  logic [DATA_W-1:0] i_rdata_d, d_rdata_d;
  logic [1:0]        gnt_c;
  logic              addr_lsb_unused;

  // Byte-lane bits are not part of the word address
  assign addr_lsb_unused = ^{i_addr[1:0], d_addr[1:0]};

  mips_bus_rr_arbiter #(
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .d_req    (d_req),
    .done     (state_q == RESP),
    .done_gnt (gnt_q),
    .gnt_c    (gnt_c)
  );

  assign address    = addr_q;
  assign read       = cmd_q.read;
  assign write      = cmd_q.write;
  assign writedata  = cmd_q.wdata;
  assign byteenable = cmd_q.be;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= GNT_INSTR;
      cmd_q   <= '0;
      addr_q  <= '0;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      i_ack   <= i_ack_d;
      d_ack   <= d_ack_d;
      i_rdata <= i_rdata_d;
      d_rdata <= d_rdata_d;
      busy    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    i_rdata_d = i_rdata;
    d_rdata_d = d_rdata;

    unique case (state_q)
      IDLE: begin
        // Latch the winner's fields; later changes on the request side are ignored
        if (gnt_c[1]) begin
          gnt_d       = GNT_DATA;
          addr_d      = {d_addr[ADDR_W-1:2], 2'b00};
          cmd_d.read  = !d_we;
          cmd_d.write = d_we;
          cmd_d.wdata = d_wdata;
          cmd_d.be    = d_be;
          state_d     = BUS;
        end else if (gnt_c[0]) begin
          gnt_d       = GNT_INSTR;
          addr_d      = {i_addr[ADDR_W-1:2], 2'b00};
          cmd_d.read  = 1'b1;
          cmd_d.write = 1'b0;
          cmd_d.wdata = '0;
          cmd_d.be    = WORD_BE_ALL;
          state_d     = BUS;
        end
      end
      BUS: begin
        if (!waitrequest) begin
          if (cmd_q.read) begin
            if (gnt_q == GNT_DATA) begin
              d_rdata_d = readdata;
            end else begin
              i_rdata_d = readdata;
            end
          end
          cmd_d.read  = 1'b0;
          cmd_d.write = 1'b0;
          i_ack_d     = (gnt_q == GNT_INSTR);
          d_ack_d     = (gnt_q == GNT_DATA);
          state_d     = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_mips_avalon_bus_master.sv
// Directed, scoreboard-checked bench for mips_avalon_bus_master with a behavioural Avalon slave.
module tb_mips_avalon_bus_master;
  import mips_bus_pkg::*;

  typedef struct packed {
    logic        is_data;
    logic [31:0] rdata;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        i_req, i_ack, d_req, d_we, d_ack;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic [31:0] address, writedata, readdata;
  logic        read, write, waitrequest, busy;
  logic [3:0]  byteenable;

  logic        f_i_req, f_i_ack, f_d_req, f_d_ack, f_read, f_write, f_busy;
  logic [31:0] f_i_addr, f_d_addr, f_d_rdata, f_address, f_readdata;
  logic [31:0] f_i_rdata_unused, f_writedata_unused;
  logic [3:0]  f_byteenable_unused;

  logic [31:0] mem [16];
  logic [3:0]  cnt;
  logic [3:0]  delay;
  logic        force_wait;

  exp_t        sb[$];
  int          n_assert;
  int          n_fail;
  int          main_left;
  int          f_dacks;
  int          f_iacks;
  logic [31:0] exp_d;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mips_avalon_bus_master #(.ARB_MODE(1), .ADDR_W(32)) u_dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata),
    .busy(busy)
  );

  mips_avalon_bus_master #(.ARB_MODE(0), .ADDR_W(32)) u_fix (
    .clk(clk), .rst(rst),
    .i_req(f_i_req), .i_addr(f_i_addr), .i_ack(f_i_ack), .i_rdata(f_i_rdata_unused),
    .d_req(f_d_req), .d_we(1'b0), .d_addr(f_d_addr), .d_wdata(32'h0), .d_be(4'hF),
    .d_ack(f_d_ack), .d_rdata(f_d_rdata),
    .address(f_address), .read(f_read), .write(f_write), .writedata(f_writedata_unused),
    .byteenable(f_byteenable_unused), .waitrequest(1'b0), .readdata(f_readdata),
    .busy(f_busy)
  );

  // Slave: 'delay' wait cycles per access, optional forced stall, garbage readdata while stalled
  assign waitrequest = force_wait | ((read | write) & (cnt != delay));
  assign readdata    = (read & ~waitrequest) ? mem[address[5:2]] : 32'hDEADBEEF;
  assign f_readdata  = f_read ? mem[f_address[5:2]] : 32'hDEADBEEF;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      mem[0] <= 32'h11111111;
      mem[2] <= 32'h22222222;
      mem[3] <= 32'h33333333;
    end else if ((read | write) && !waitrequest) begin
      cnt <= '0;
      if (write) begin
        for (int b = 0; b < 4; b++) begin
          if (byteenable[b]) mem[address[5:2]][8*b +: 8] <= writedata[8*b +: 8];
        end
      end
    end else if ((read | write) && (cnt != delay)) begin
      cnt <= cnt + 4'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_ack(input logic is_data, input logic [31:0] v);
    exp_t e;
    e.is_data = is_data;
    e.rdata   = v;
    sb.push_back(e);
  endtask

  // Advance to the next falling edge and score any acknowledges
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (i_ack || d_ack) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'({i_ack, d_ack}), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("ack_src", 32'({i_ack, d_ack}), e.is_data ? 32'd1 : 32'd2);
        chk(e.is_data ? "d_rdata" : "i_rdata", e.is_data ? d_rdata : i_rdata, e.rdata);
        if (main_left > 0) main_left--;
        if (main_left == 0) begin
          i_req = 1'b0;
          d_req = 1'b0;
        end
      end
    end
    if (f_d_ack) begin
      f_dacks++;
      chk("f_d_rdata", f_d_rdata, 32'h22222222);
      if (f_dacks == 4) begin
        f_d_req = 1'b0;
        f_i_req = 1'b0;
      end
    end
    if (f_i_ack) f_iacks++;
    chk("f_write", 32'(f_write), 32'd0);
  endtask

  // Run until the scoreboard empties (bounded), then one more cycle so the DUT is back in IDLE
  task automatic drain(input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    if (sb.size() != 0) begin
      chk("ack_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
      main_left = 0;
      i_req = 1'b0;
      d_req = 1'b0;
    end
    tick();
  endtask

  task automatic data_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, input logic [31:0] load_val);
    d_we      = we;
    d_addr    = addr;
    d_wdata   = wdata;
    d_be      = be;
    d_req     = 1'b1;
    main_left = 1;
    if (!we) exp_d = load_val;
    expect_ack(1'b1, exp_d);
  endtask

  initial begin
    n_assert = 0; n_fail = 0; main_left = 0; f_dacks = 0; f_iacks = 0;
    rst = 1'b1; force_wait = 1'b0; delay = 4'd0; exp_d = '0;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    f_i_req = 1'b0; f_d_req = 1'b0; f_i_addr = '0; f_d_addr = '0;

    // Reset state
    tick(); tick();
    chk("rst_read", 32'(read), 32'd0);
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_address", address, 32'd0);
    chk("rst_writedata", writedata, 32'd0);
    chk("rst_byteenable", 32'(byteenable), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_acks", 32'({i_ack, d_ack}), 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    rst = 1'b0;

    // Contention: round-robin DUT alternates starting with data; fixed DUT only serves data
    delay = 4'd1;
    i_addr = 32'hBFC0000C; d_addr = 32'hBFC00008; d_we = 1'b0; d_be = 4'hF;
    i_req = 1'b1; d_req = 1'b1; main_left = 4;
    expect_ack(1'b1, 32'h22222222);
    expect_ack(1'b0, 32'h33333333);
    expect_ack(1'b1, 32'h22222222);
    expect_ack(1'b0, 32'h33333333);
    exp_d = 32'h22222222;
    f_i_addr = 32'hBFC0000C; f_d_addr = 32'hBFC00008; f_i_req = 1'b1; f_d_req = 1'b1;
    drain(60);
    chk("fixed_data_acks", 32'(f_dacks), 32'd4);
    chk("fixed_instr_acks", 32'(f_iacks), 32'd0);
    chk("fixed_busy_end", 32'(f_busy), 32'd0);

    // Fetch with two wait states: command held, single ack pulse
    delay = 4'd2;
    i_addr = 32'hBFC00000; i_req = 1'b1; main_left = 1;
    expect_ack(1'b0, 32'h11111111);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("fetch_read_hold", 32'(read), 32'd1);
      chk("fetch_addr_hold", address, 32'hBFC00000);
      chk("fetch_be", 32'(byteenable), 32'hF);
    end
    tick();
    chk("fetch_ack", 32'(i_ack), 32'd1);
    chk("fetch_read_drop", 32'(read), 32'd0);
    tick();
    chk("fetch_ack_pulse", 32'(i_ack), 32'd0);
    chk("fetch_rdata_held", i_rdata, 32'h11111111);
    chk("fetch_busy_end", 32'(busy), 32'd0);

    // Load, store with partial byte enables (d_rdata untouched), then load back
    delay = 4'd0;
    data_access(1'b0, 32'hBFC00008, 32'h0, 4'hF, 32'h22222222);
    drain(20);
    data_access(1'b1, 32'hBFC00004, 32'hAABBCCDD, 4'b0110, 32'h0);
    tick();
    chk("store_write", 32'(write), 32'd1);
    chk("store_read", 32'(read), 32'd0);
    chk("store_be", 32'(byteenable), 32'h6);
    chk("store_wdata", writedata, 32'hAABBCCDD);
    chk("store_addr", address, 32'hBFC00004);
    drain(20);
    data_access(1'b0, 32'hBFC00007, 32'h0, 4'hF, 32'h00BBCC00);
    tick();
    chk("load_addr_aligned", address, 32'hBFC00004);
    drain(20);

    // Stall for 5 cycles while the request fields churn
    force_wait = 1'b1;
    data_access(1'b1, 32'hBFC00010, 32'hCAFEF00D, 4'hF, 32'h0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_write", 32'(write), 32'd1);
      chk("stall_addr", address, 32'hBFC00010);
      chk("stall_wdata", writedata, 32'hCAFEF00D);
      chk("stall_be", 32'(byteenable), 32'hF);
      d_addr  = $urandom;
      d_wdata = $urandom;
    end
    force_wait = 1'b0;
    drain(20);
    data_access(1'b0, 32'hBFC00010, 32'h0, 4'hF, 32'hCAFEF00D);
    drain(20);

    // Reset in the middle of a stalled fetch
    force_wait = 1'b1;
    i_addr = 32'hBFC00000; i_req = 1'b1; main_left = 1;
    tick();
    chk("mid_read_active", 32'(read), 32'd1);
    tick();
    rst = 1'b1; i_req = 1'b0; force_wait = 1'b0; main_left = 0;
    tick();
    chk("rst_mid_read", 32'(read), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_ack", 32'(i_ack), 32'd0);
    chk("rst_mid_i_rdata", i_rdata, 32'd0);
    chk("rst_mid_d_rdata", d_rdata, 32'd0);
    rst = 1'b0; exp_d = '0;
    tick();

    // Zero-wait fetch: minimum latency and busy timing
    delay = 4'd0;
    i_addr = 32'hBFC0000C; i_req = 1'b1; main_left = 1;
    expect_ack(1'b0, 32'h33333333);
    tick();
    chk("min_read", 32'(read), 32'd1);
    chk("min_busy_bus", 32'(busy), 32'd1);
    chk("min_no_ack_yet", 32'(i_ack), 32'd0);
    tick();
    chk("min_ack", 32'(i_ack), 32'd1);
    chk("min_read_one_cycle", 32'(read), 32'd0);
    chk("min_busy_resp", 32'(busy), 32'd1);
    tick();
    chk("min_busy_idle", 32'(busy), 32'd0);
    chk("min_ack_pulse", 32'(i_ack), 32'd0);
    chk("min_read_idle", 32'(read), 32'd0);
    drain(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
